// File: rtl/qrs_interval_meter.sv
// qrs_interval_meter: beat-timing unit that sits after the R-peak detector.
// It measures the R-R interval with refractory gating and a missed-beat
// timeout. It measures the QRS width on the Nth falling slope edge after a
// peak. It keeps a running average of R-R and flags irregular beats against it.
module qrs_interval_meter #(
  parameter int CNT_W     = 12,
  parameter int QRS_LIMIT = 30,
  parameter int QRS_EDGES = 2,
  parameter int REFRACT   = 72,
  parameter int RR_MAX    = 2000,
  parameter int AVG_LOG2  = 3,
  parameter int IRR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             r_peak_i,
  input  logic             slope_i,
  output logic [CNT_W-1:0] rr_int,
  output logic             rr_valid,
  output logic [CNT_W-1:0] qrs_width,
  output logic             qrs_valid,
  output logic [CNT_W-1:0] rr_avg,
  output logic             avg_valid,
  output logic             irregular,
  output logic             missed_beat
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = CNT_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int EDGE_W = 3;

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  REFRACT_C   = CNT_W'(REFRACT);
  localparam logic [CNT_W-1:0]  RR_MAX_C    = CNT_W'(RR_MAX);
  localparam logic [CNT_W-1:0]  QRS_LIMIT_C = CNT_W'(QRS_LIMIT);
  localparam logic [EDGE_W-1:0] EDGES_C     = EDGE_W'(QRS_EDGES);
  localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(DEPTH);

  // IDLE: no reference beat yet; REFRACTORY: peaks ignored; TRACK: waiting for next beat
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REFRACT = 2'd1,
    S_TRACK   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                slope_q, slope_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]    rr_int_q, rr_int_d;
  logic                rr_valid_q, rr_valid_d;
  logic [CNT_W-1:0]    qrs_width_q, qrs_width_d;
  logic                qrs_valid_q, qrs_valid_d;
  logic [CNT_W-1:0]    rr_avg_q, rr_avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic                irregular_q, irregular_d;
  logic                missed_beat_q, missed_beat_d;
  logic                avg_upd_q, avg_upd_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    ring_q [DEPTH];
  logic [CNT_W-1:0]    ring_d [DEPTH];

  // Shared decode of the current cycle's events
  logic             accept;
  logic             capture;
  logic [CNT_W-1:0] cnt_inc;
  logic             refract_done;
  logic             timeout;
  logic             edge_hit;
  logic [CNT_W-1:0] rr_diff;
  logic [CNT_W-1:0] irr_thr;

  assign accept       = r_peak_i && (state_q != S_REFRACT);
  assign capture      = accept && (state_q == S_TRACK);
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign refract_done = sample_en && (cnt_inc >= REFRACT_C);
  assign timeout      = (state_q == S_TRACK) && !accept && sample_en && (cnt_inc >= RR_MAX_C);
  assign edge_hit     = sample_en && slope_q && !slope_i && (state_q != S_IDLE)
                        && !accept && (edge_cnt_q < EDGES_C);
  assign rr_diff      = (cnt_q >= rr_avg_q) ? cnt_q - rr_avg_q : rr_avg_q - cnt_q;
  assign irr_thr      = rr_avg_q >> IRR_SHIFT;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a peak restarts refractory, the counter ends it, the timeout drops the reference
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_REFRACT;
      S_REFRACT: if (refract_done) state_d = S_TRACK;
      S_TRACK: begin
        if (accept)       state_d = S_REFRACT;
        else if (timeout) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: counter, QRS edges, interval capture and averaging
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    cnt_d         = cnt_q;
    slope_d       = slope_q;
    edge_cnt_d    = edge_cnt_q;
    rr_int_d      = rr_int_q;
    rr_valid_d    = 1'b0;
    qrs_width_d   = qrs_width_q;
    qrs_valid_d   = 1'b0;
    rr_avg_d      = rr_avg_q;
    avg_valid_d   = avg_valid_q;
    irregular_d   = 1'b0;
    missed_beat_d = 1'b0;
    avg_upd_d     = 1'b0;
    sum_d         = sum_q;
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    ring_d        = ring_q;

    // Sample counter; an accepted peak wins over a same-cycle increment
    if (accept || timeout) cnt_d = '0;
    else if (sample_en)    cnt_d = cnt_inc;

    if (sample_en) slope_d = slope_i;

    // QRS window closes on the Nth falling edge after the peak
    if (accept) begin
      edge_cnt_d = '0;
    end else if (edge_hit) begin
      edge_cnt_d = edge_cnt_q + EDGE_W'(1);
      if ((edge_cnt_q == EDGES_C - EDGE_W'(1)) && (cnt_q <= QRS_LIMIT_C)) begin
        qrs_width_d = cnt_q;
        qrs_valid_d = 1'b1;
      end
    end

    missed_beat_d = timeout;

    // Interval capture: cnt still holds the pre-peak count; irregular uses the old average
    if (capture) begin
      rr_int_d         = cnt_q;
      rr_valid_d       = 1'b1;
      irregular_d      = avg_valid_q && (rr_diff > irr_thr);
      ring_d[wr_ptr_q] = cnt_q;
      sum_d            = sum_q - SUM_W'(ring_q[wr_ptr_q]) + SUM_W'(cnt_q);
      wr_ptr_d         = wr_ptr_q + AVG_LOG2'(1);
      fill_d           = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      avg_upd_d        = 1'b1;
    end

    // Average output follows the sum one cycle later
    if (avg_upd_q) begin
      rr_avg_d    = CNT_W'(sum_q >> AVG_LOG2);
      avg_valid_d = (fill_q == FILL_FULL);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      slope_q       <= 1'b1;
      edge_cnt_q    <= '0;
      rr_int_q      <= '0;
      rr_valid_q    <= 1'b0;
      qrs_width_q   <= '0;
      qrs_valid_q   <= 1'b0;
      rr_avg_q      <= '0;
      avg_valid_q   <= 1'b0;
      irregular_q   <= 1'b0;
      missed_beat_q <= 1'b0;
      avg_upd_q     <= 1'b0;
      sum_q         <= '0;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      // NOTE: the history ring is small flop storage and is cleared with everything else,
      // so unfilled slots read as zero and a reset discards old history.
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
    end else begin
      cnt_q         <= cnt_d;
      slope_q       <= slope_d;
      edge_cnt_q    <= edge_cnt_d;
      rr_int_q      <= rr_int_d;
      rr_valid_q    <= rr_valid_d;
      qrs_width_q   <= qrs_width_d;
      qrs_valid_q   <= qrs_valid_d;
      rr_avg_q      <= rr_avg_d;
      avg_valid_q   <= avg_valid_d;
      irregular_q   <= irregular_d;
      missed_beat_q <= missed_beat_d;
      avg_upd_q     <= avg_upd_d;
      sum_q         <= sum_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      ring_q        <= ring_d;
    end
  end

  assign rr_int      = rr_int_q;
  assign rr_valid    = rr_valid_q;
  assign qrs_width   = qrs_width_q;
  assign qrs_valid   = qrs_valid_q;
  assign rr_avg      = rr_avg_q;
  assign avg_valid   = avg_valid_q;
  assign irregular   = irregular_q;
  assign missed_beat = missed_beat_q;

endmodule

// File: tb/tb_qrs_interval_meter.sv
// Testbench for qrs_interval_meter. A table of beats is applied with
// hand-computed expectations. The run then covers a reset mid-operation,
// followed by randomized stimulus. A behavioural model is compared every
// cycle throughout.
module tb_qrs_interval_meter;

  localparam int CNT_W     = 12;
  localparam int QRS_LIMIT = 30;
  localparam int QRS_EDGES = 2;
  localparam int REFRACT   = 72;
  localparam int RR_MAX    = 2000;
  localparam int AVG_LOG2  = 3;
  localparam int IRR_SHIFT = 2;
  localparam int CNT_SAT   = (1 << CNT_W) - 1;
  localparam int DEPTH     = 1 << AVG_LOG2;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  logic             r_peak_i;
  logic             slope_i;
  logic [CNT_W-1:0] rr_int;
  logic             rr_valid;
  logic [CNT_W-1:0] qrs_width;
  logic             qrs_valid;
  logic [CNT_W-1:0] rr_avg;
  logic             avg_valid;
  logic             irregular;
  logic             missed_beat;

  always #5 clk = ~clk;

  qrs_interval_meter #(
    .CNT_W(CNT_W), .QRS_LIMIT(QRS_LIMIT), .QRS_EDGES(QRS_EDGES), .REFRACT(REFRACT),
    .RR_MAX(RR_MAX), .AVG_LOG2(AVG_LOG2), .IRR_SHIFT(IRR_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .r_peak_i(r_peak_i), .slope_i(slope_i),
    .rr_int(rr_int), .rr_valid(rr_valid), .qrs_width(qrs_width), .qrs_valid(qrs_valid),
    .rr_avg(rr_avg), .avg_valid(avg_valid), .irregular(irregular), .missed_beat(missed_beat)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int rr_int; int rr_valid; int qrs_width; int qrs_valid;
    int rr_avg; int avg_valid; int irregular; int missed_beat;
  } out_t;

  out_t exp_o;
  bit   m_have_ref;   // a reference beat exists (not idle)
  int   m_since;      // samples since the last accepted peak
  int   m_edges;      // falling edges seen since the last accepted peak
  bit   m_slope;      // slope at the last sample
  int   hist[$];      // most recent intervals, newest at the back
  bit   m_pend;
  int   m_pend_avg;
  int   m_pend_v;

  task automatic model_step(input bit r, input bit pk, input bit sl, input bit se);
    int  cur_avg, cur_avgv, s, diff;
    bit  refr, acc;
    if (r) begin
      m_have_ref = 0; m_since = 0; m_edges = 0; m_slope = 1; m_pend = 0;
      hist.delete();
      exp_o.rr_int = 0; exp_o.rr_valid = 0; exp_o.qrs_width = 0; exp_o.qrs_valid = 0;
      exp_o.rr_avg = 0; exp_o.avg_valid = 0; exp_o.irregular = 0; exp_o.missed_beat = 0;
      return;
    end
    cur_avg  = exp_o.rr_avg;
    cur_avgv = exp_o.avg_valid;
    exp_o.rr_valid = 0; exp_o.qrs_valid = 0; exp_o.irregular = 0; exp_o.missed_beat = 0;
    if (m_pend) begin
      exp_o.rr_avg = m_pend_avg; exp_o.avg_valid = m_pend_v; m_pend = 0;
    end
    refr = m_have_ref && (m_since < REFRACT);
    acc  = pk && !refr;
    if (acc) begin
      if (m_have_ref) begin
        diff = (m_since > cur_avg) ? m_since - cur_avg : cur_avg - m_since;
        exp_o.rr_int    = m_since;
        exp_o.rr_valid  = 1;
        exp_o.irregular = (cur_avgv != 0 && diff > (cur_avg >> IRR_SHIFT)) ? 1 : 0;
        hist.push_back(m_since);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += hist[i];
        m_pend = 1; m_pend_avg = s / DEPTH; m_pend_v = (hist.size() == DEPTH) ? 1 : 0;
      end
      m_have_ref = 1; m_since = 0; m_edges = 0;
    end else begin
      if (m_have_ref && se && m_slope && !sl && m_edges < QRS_EDGES) begin
        m_edges++;
        if (m_edges == QRS_EDGES && m_since <= QRS_LIMIT) begin
          exp_o.qrs_width = m_since; exp_o.qrs_valid = 1;
        end
      end
      if (se) begin
        if (m_have_ref && !refr && m_since + 1 >= RR_MAX) begin
          exp_o.missed_beat = 1; m_have_ref = 0; m_since = 0;
        end else if (m_since < CNT_SAT) begin
          m_since++;
        end
      end
    end
    if (se) m_slope = sl;
  endtask

  task automatic compare_model();
    check("m_rr_int",      32'(rr_int),      exp_o.rr_int);
    check("m_rr_valid",    32'(rr_valid),    exp_o.rr_valid);
    check("m_qrs_width",   32'(qrs_width),   exp_o.qrs_width);
    check("m_qrs_valid",   32'(qrs_valid),   exp_o.qrs_valid);
    check("m_rr_avg",      32'(rr_avg),      exp_o.rr_avg);
    check("m_avg_valid",   32'(avg_valid),   exp_o.avg_valid);
    check("m_irregular",   32'(irregular),   exp_o.irregular);
    check("m_missed_beat", 32'(missed_beat), exp_o.missed_beat);
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic cycle(input bit r, input bit pk, input bit sl, input bit se);
    @(negedge clk);
    rst = r; r_peak_i = pk; slope_i = sl; sample_en = se;
    model_step(r, pk, sl, se);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // ---------------- table of beats ----------------
  // Each row: a peak, then 'gap' idle samples (cycle k of the gap sees cnt == k).
  // Falling edges at e1/e2 and a spurious peak at xpk (-1 = none).
  // The exp_* fields are the outputs after the peak, after the first gap cycle,
  // and by the end of the gap.
  typedef struct {
    int gap; int e1; int e2; int xpk;
    int rr_v; int rr; int irr; int avg; int avg_v; int qrs_v; int qrs_w; int missed;
  } beat_t;

  beat_t beats[16];

  task automatic run_beat(input int idx);
    beat_t b;
    int    qrs_seen, miss_k;
    b = beats[idx];
    qrs_seen = 0;
    miss_k   = -1;
    cycle(0, 1, 1, 1);
    check($sformatf("b%0d_rr_valid", idx), 32'(rr_valid), b.rr_v);
    check($sformatf("b%0d_rr_int", idx), 32'(rr_int), b.rr);
    check($sformatf("b%0d_irregular", idx), 32'(irregular), b.irr);
    for (int k = 0; k < b.gap; k++) begin
      cycle(0, (k == b.xpk), !(k == b.e1 || k == b.e2), 1);
      if (qrs_valid) qrs_seen = 1;
      if (missed_beat) miss_k = k;
      if (k == 0) begin
        check($sformatf("b%0d_rr_avg", idx), 32'(rr_avg), b.avg);
        check($sformatf("b%0d_avg_valid", idx), 32'(avg_valid), b.avg_v);
        check($sformatf("b%0d_rr_pulse_end", idx), 32'(rr_valid), 0);
      end
    end
    check($sformatf("b%0d_qrs_seen", idx), qrs_seen, b.qrs_v);
    check($sformatf("b%0d_qrs_width", idx), 32'(qrs_width), b.qrs_w);
    check($sformatf("b%0d_missed_at", idx), miss_k, b.missed ? RR_MAX - 1 : -1);
  endtask

  initial begin
    bit sl_r;
    int pdiv[6];
    beats[0]  = '{300,  8, 20, 40, 0,   0, 0,   0, 0, 1, 20, 0};
    beats[1]  = '{300,  8, 35, -1, 1, 300, 0,  37, 0, 0, 20, 0};
    beats[2]  = '{300, -1, -1, -1, 1, 300, 0,  75, 0, 0, 20, 0};
    beats[3]  = '{300, -1, -1, -1, 1, 300, 0, 112, 0, 0, 20, 0};
    beats[4]  = '{300, -1, -1, -1, 1, 300, 0, 150, 0, 0, 20, 0};
    beats[5]  = '{300, -1, -1, -1, 1, 300, 0, 187, 0, 0, 20, 0};
    beats[6]  = '{300, -1, -1, -1, 1, 300, 0, 225, 0, 0, 20, 0};
    beats[7]  = '{300, -1, -1, -1, 1, 300, 0, 262, 0, 0, 20, 0};
    beats[8]  = '{400, -1, -1, -1, 1, 300, 0, 300, 1, 0, 20, 0};
    beats[9]  = '{300, -1, -1, -1, 1, 400, 1, 312, 1, 0, 20, 0};
    beats[10] = '{2100, 5, 10, -1, 1, 300, 0, 312, 1, 1, 10, 1};
    beats[11] = '{250, -1, -1, -1, 0, 300, 0, 312, 1, 0, 10, 0};
    beats[12] = '{300,  3, 30, -1, 1, 250, 0, 306, 1, 1, 30, 0};
    beats[13] = '{382,  4, 31, -1, 1, 300, 0, 306, 1, 0, 30, 0};
    beats[14] = '{100, -1, -1, -1, 1, 382, 0, 316, 1, 0, 30, 0};
    beats[15] = '{50,  -1, -1, -1, 1, 100, 1, 291, 1, 0, 30, 0};

    rst = 1'b1; sample_en = 1'b0; r_peak_i = 1'b0; slope_i = 1'b1;
    cycle(1, 0, 1, 0);
    cycle(1, 1, 0, 1);
    check("rst_rr_int", 32'(rr_int), 0);
    check("rst_rr_avg", 32'(rr_avg), 0);
    check("rst_avg_valid", 32'(avg_valid), 0);
    check("rst_qrs_width", 32'(qrs_width), 0);
    cycle(0, 0, 1, 1);

    for (int i = 0; i < 16; i++) run_beat(i);

    // Reset between peaks after the average is valid, then restart
    cycle(1, 0, 1, 1);
    check("mid_rst_rr_int", 32'(rr_int), 0);
    check("mid_rst_rr_avg", 32'(rr_avg), 0);
    check("mid_rst_avg_valid", 32'(avg_valid), 0);
    check("mid_rst_qrs_width", 32'(qrs_width), 0);
    for (int k = 0; k < 10; k++) cycle(0, 0, 1, 1);
    cycle(0, 1, 1, 1);
    check("post_rst_first_rr_valid", 32'(rr_valid), 0);
    for (int k = 0; k < 300; k++) cycle(0, 0, 1, 1);
    cycle(0, 1, 1, 1);
    check("post_rst_rr_valid", 32'(rr_valid), 1);
    check("post_rst_rr_int", 32'(rr_int), 300);
    cycle(0, 0, 1, 1);
    check("post_rst_rr_avg", 32'(rr_avg), 37);
    check("post_rst_avg_valid", 32'(avg_valid), 0);

    // Randomized segments with different beat rates, sparse samples and rare resets
    pdiv = '{150, 400, 3000, 60, 250, 5000};
    sl_r = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 4000; c++) begin
        bit se_r, pk_r, rs_r;
        se_r = ($urandom_range(0, 3) != 0);
        pk_r = ($urandom_range(0, pdiv[seg]) == 0);
        rs_r = ($urandom_range(0, 4999) == 0);
        if ($urandom_range(0, 3) == 0) sl_r = !sl_r;
        cycle(rs_r, pk_r, sl_r, se_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
